// File: rtl/risc_fetch.sv
// Instruction-fetch stage for the 13-bit RISC core: owns the PC, latches the
// word returned by instruction memory into ir, and handles stall, branch and HALT.
module risc_fetch #(
    parameter logic [4:0] RESET_PC    = 5'd0,
    parameter logic [3:0] HALT_OPCODE = 4'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [4:0]  pc,
    input  logic [12:0] instruction,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [4:0]  branch_target,
    output logic [12:0] ir,
    output logic [4:0]  ir_pc,
    output logic        ir_valid,
    output logic        halted
);

    logic [4:0]  pc_q, pc_d;
    logic [12:0] ir_q, ir_d;
    logic [4:0]  ir_pc_q, ir_pc_d;
    logic        ir_valid_q, ir_valid_d;
    logic        halted_q, halted_d;
    logic        is_halt;

    assign is_halt = (instruction[12:9] == HALT_OPCODE);

    // Priority: branch, halted hold, stall, HALT detect, normal fetch.
    always_comb begin
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        halted_d   = halted_q;
        if (branch_taken) begin
            pc_d       = branch_target;
            ir_valid_d = 1'b0;
            halted_d   = 1'b0;
        end else if (halted_q) begin
            ir_valid_d = 1'b0;
        end else if (stall) begin
            ir_valid_d = ir_valid_q;
        end else if (is_halt) begin
            halted_d   = 1'b1;
            ir_valid_d = 1'b0;
        end else begin
            ir_d       = instruction;
            ir_pc_d    = pc_q;
            ir_valid_d = 1'b1;
            pc_d       = pc_q + 5'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            ir_q       <= 13'h0000;
            ir_pc_q    <= 5'd0;
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            halted_q   <= halted_d;
        end
    end

    assign pc       = pc_q;
    assign ir       = ir_q;
    assign ir_pc    = ir_pc_q;
    assign ir_valid = ir_valid_q;
    assign halted   = halted_q;

endmodule

// File: tb/tb_risc_fetch.sv
// Directed bench for risc_fetch: a behavioural fetch model checked every cycle,
// plus literal expectations from the test plan.
module tb_risc_fetch;

    logic        clk;
    logic        reset;
    logic [4:0]  pc;
    logic [12:0] instruction;
    logic        stall;
    logic        branch_taken;
    logic [4:0]  branch_target;
    logic [12:0] ir;
    logic [4:0]  ir_pc;
    logic        ir_valid;
    logic        halted;

    logic [12:0] mem [32];
    int total = 0;
    int bad   = 0;

    risc_fetch dut (
        .clk          (clk),
        .reset        (reset),
        .pc           (pc),
        .instruction  (instruction),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .ir           (ir),
        .ir_pc        (ir_pc),
        .ir_valid     (ir_valid),
        .halted       (halted)
    );

    assign instruction = mem[pc];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: what the fetch stage must be showing.
    int          m_pc;
    logic [12:0] m_ir;
    int          m_ir_pc;
    bit          m_valid;
    bit          m_halted;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc = 0; m_ir = 13'h0; m_ir_pc = 0; m_valid = 0; m_halted = 0;
        end else if (branch_taken) begin
            m_pc = int'(branch_target);
            m_valid = 0;
            m_halted = 0;
        end else if (m_halted) begin
            m_valid = 0;
        end else if (stall) begin
            // nothing moves
        end else if ((mem[m_pc] >> 9) == 0) begin
            m_halted = 1;
            m_valid = 0;
        end else begin
            m_ir = mem[m_pc];
            m_ir_pc = m_pc;
            m_valid = 1;
            m_pc = (m_pc + 1) % 32;
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        cmp("model_pc", int'(pc), m_pc);
        cmp("model_ir", int'(ir), int'(m_ir));
        cmp("model_ir_pc", int'(ir_pc), m_ir_pc);
        cmp("model_ir_valid", int'(ir_valid), int'(m_valid));
        cmp("model_halted", int'(halted), int'(m_halted));
    end

    task automatic load_standard();
        for (int a = 0; a < 32; a++) mem[a] = 13'h1000 | 13'(a);
        mem[0]  = 13'h1c00;
        mem[1]  = 13'h1c11;
        mem[2]  = 13'h1c22;
        mem[3]  = 13'h1c33;
        mem[8]  = 13'h0208;
        mem[21] = 13'h1e08;
        mem[28] = 13'h1e7f;
        mem[29] = 13'h0000;
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit seen;
        load_standard();
        reset = 1'b1;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_target = 5'd17;
        edge1();
        edge1();
        reset = 1'b0;
        cmp("reset_pc", int'(pc), 0);
        cmp("reset_ir_valid", int'(ir_valid), 0);
        cmp("reset_ir", int'(ir), 0);

        // Sequential fetch
        edge1();
        cmp("e1_ir", int'(ir), 'h1c00);
        cmp("e1_ir_pc", int'(ir_pc), 0);
        cmp("e1_pc", int'(pc), 1);
        repeat (8) edge1();
        cmp("e9_ir", int'(ir), 'h0208);
        cmp("e9_ir_pc", int'(ir_pc), 8);

        // Restart and stall
        reset = 1'b1;
        edge1();
        reset = 1'b0;
        repeat (3) edge1();
        cmp("pre_stall_ir", int'(ir), 'h1c22);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            edge1();
            cmp("stall_ir", int'(ir), 'h1c22);
            cmp("stall_ir_pc", int'(ir_pc), 2);
            cmp("stall_pc", int'(pc), 3);
        end
        stall = 1'b0;
        edge1();
        cmp("post_stall_ir", int'(ir), 'h1c33);

        // Branch together with stall
        branch_taken = 1'b1;
        branch_target = 5'd21;
        stall = 1'b1;
        edge1();
        branch_taken = 1'b0;
        branch_target = 5'd5;
        stall = 1'b0;
        cmp("br_pc", int'(pc), 21);
        cmp("br_ir_valid", int'(ir_valid), 0);
        cmp("br_ir_hold", int'(ir), 'h1c33);
        edge1();
        cmp("br_ir", int'(ir), 'h1e08);
        cmp("br_ir_pc", int'(ir_pc), 21);
        cmp("br_valid", int'(ir_valid), 1);

        // Run to HALT at 29
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            edge1();
            seen = halted;
        end
        cmp("halt_reached", int'(seen), 1);
        cmp("halt_pc", int'(pc), 29);
        cmp("halt_valid", int'(ir_valid), 0);
        cmp("halt_last_ir", int'(ir), 'h1e7f);
        cmp("halt_last_ir_pc", int'(ir_pc), 28);
        for (int i = 0; i < 5; i++) begin
            edge1();
            cmp("halt_pc_stable", int'(pc), 29);
        end
        branch_taken = 1'b1;
        branch_target = 5'd8;
        edge1();
        branch_taken = 1'b0;
        cmp("resume_halted", int'(halted), 0);
        cmp("resume_pc", int'(pc), 8);
        edge1();
        cmp("resume_ir", int'(ir), 'h0208);

        // Wrap-around with no HALT words
        mem[29] = 13'h1d1d;
        branch_taken = 1'b1;
        branch_target = 5'd30;
        edge1();
        branch_taken = 1'b0;
        for (int i = 0; i < 4; i++) begin
            edge1();
            cmp("wrap_ir_pc", int'(ir_pc), (30 + i) % 32);
            cmp("wrap_pc", int'(pc), (31 + i) % 32);
        end

        // Async reset between edges while pc=12 and ir_valid=1
        branch_taken = 1'b1;
        branch_target = 5'd10;
        edge1();
        branch_taken = 1'b0;
        repeat (2) edge1();
        cmp("pre_rst_pc", int'(pc), 12);
        cmp("pre_rst_valid", int'(ir_valid), 1);
        #1 reset = 1'b1;
        #1;
        cmp("arst_pc", int'(pc), 0);
        cmp("arst_ir", int'(ir), 0);
        cmp("arst_ir_pc", int'(ir_pc), 0);
        cmp("arst_valid", int'(ir_valid), 0);
        cmp("arst_halted", int'(halted), 0);
        #1 reset = 1'b0;
        edge1();
        cmp("restart_ir", int'(ir), 'h1c00);
        cmp("restart_ir_pc", int'(ir_pc), 0);
        cmp("restart_pc", int'(pc), 1);

        edge1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
